// File: rtl/clock_enables_pkg.sv
// Shared constants for the Lynx clock-enable tree: divisors, CPU counter width, speed encoding.
package lynx_clk_pkg;

  localparam int DIV_SLOW  = 6;
  localparam int DIV_FAST  = 4;
  localparam int DIV_1M    = 24;
  localparam int CPU_CNT_W = 3;

  localparam logic SPEED_4M = 1'b0;
  localparam logic SPEED_6M = 1'b1;

  typedef logic [CPU_CNT_W-1:0] cpu_cnt_t;

  function automatic cpu_cnt_t cpu_div(input logic turbo);
    return turbo ? cpu_cnt_t'(DIV_FAST) : cpu_cnt_t'(DIV_SLOW);
  endfunction

endpackage

// File: rtl/clock_enables_if.sv
// Strobe bundle between clock_enables and the Lynx core.
// The wait_n request line exists only when CE_WAIT_EN is defined.
interface clock_enables_if;
  logic turbo;
`ifdef CE_WAIT_EN
  logic wait_n;
`endif
  logic ce_p;
  logic ce_n;
  logic ce_pix;
  logic ce_1m;
  logic speed;
  logic por_n;

`ifdef CE_WAIT_EN
  modport master (input turbo, input wait_n,
                  output ce_p, output ce_n, output ce_pix, output ce_1m, output speed, output por_n);
  modport slave  (output turbo, output wait_n,
                  input ce_p, input ce_n, input ce_pix, input ce_1m, input speed, input por_n);
`else
  modport master (input turbo,
                  output ce_p, output ce_n, output ce_pix, output ce_1m, output speed, output por_n);
  modport slave  (output turbo,
                  input ce_p, input ce_n, input ce_pix, input ce_1m, input speed, input por_n);
`endif
endinterface

// File: rtl/clock_enables_power_on_reset.sv
// Power-on reset: saturating POR_BITS counter, por_n rises once the counter reaches all-ones.
module power_on_reset #(
  parameter int POR_BITS = 16
) (
  input  logic clock,
  input  logic reset,
  output logic por_n
);

  logic [POR_BITS-1:0] por_cnt;
  logic                por_done;

  assign por_done = &por_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      por_cnt <= '0;
      por_n   <= 1'b0;
    end else begin
      if (!por_done)
        por_cnt <= por_cnt + POR_BITS'(1);
      por_n <= por_done;
    end
  end

endmodule

// File: rtl/clock_enables.sv
// Clock-enable generator for the Lynx core: CPU phase enables, pixel, 1 MHz and POR release.
// Optional CE_WAIT_EN adds a wait_n input that stretches the CPU period at its boundary.
module clock_enables
  import lynx_clk_pkg::*;
#(
  parameter int POR_BITS = 16
) (
  input  logic            clock,
  input  logic            reset,
  clock_enables_if.master bus
);

  cpu_cnt_t   cpu_cnt;
  cpu_cnt_t   div;
  cpu_cnt_t   half_m1;
  logic       cpu_end;
  logic       cpu_go;
  logic       pix_tgl;
  logic [4:0] cnt24;

`ifdef CE_WAIT_EN
  assign cpu_go = bus.wait_n;
`else
  assign cpu_go = 1'b1;
`endif

  assign cpu_end = (cpu_cnt == div - cpu_cnt_t'(1));
  assign half_m1 = (div >> 1) - cpu_cnt_t'(1);

  // Divisor and speed only change at a period boundary, so a CPU period is never cut short.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_cnt   <= '0;
      div       <= cpu_div(1'b0);
      bus.speed <= SPEED_4M;
      bus.ce_p  <= 1'b0;
      bus.ce_n  <= 1'b0;
    end else begin
      bus.ce_p <= cpu_end & cpu_go;
      bus.ce_n <= (cpu_cnt == half_m1);
      if (cpu_end) begin
        if (cpu_go) begin
          cpu_cnt   <= '0;
          div       <= cpu_div(bus.turbo);
          bus.speed <= bus.turbo ? SPEED_6M : SPEED_4M;
        end
      end else begin
        cpu_cnt <= cpu_cnt + cpu_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_tgl    <= 1'b0;
      bus.ce_pix <= 1'b0;
      cnt24      <= '0;
      bus.ce_1m  <= 1'b0;
    end else begin
      pix_tgl    <= ~pix_tgl;
      bus.ce_pix <= pix_tgl;
      bus.ce_1m  <= (cnt24 == 5'(DIV_1M - 1));
      if (cnt24 == 5'(DIV_1M - 1))
        cnt24 <= '0;
      else
        cnt24 <= cnt24 + 5'd1;
    end
  end

  power_on_reset #(
    .POR_BITS (POR_BITS)
  ) u_por (
    .clock (clock),
    .reset (reset),
    .por_n (bus.por_n)
  );

endmodule

// File: tb/tb_clock_enables.sv
// Scoreboard bench for clock_enables: expected strobe edges are queued with the stimulus and
// popped as the DUT pulses; edge k is sampled 1 time unit after the k-th rising edge.
module tb_clock_enables;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  int   q_p[$];
  int   q_n[$];
  int   q_pix[$];
  int   q_1m[$];

  clock_enables_if bus();

  clock_enables #(.POR_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic do_reset(input logic t);
    reset     = 1'b0;
    bus.turbo = t;
`ifdef CE_WAIT_EN
    bus.wait_n = 1'b1;
`endif
    q_p.delete();
    q_n.delete();
    q_pix.delete();
    q_1m.delete();
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.turbo = 1'b1;
`ifdef CE_WAIT_EN
    bus.wait_n = 1'b1;
`endif
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if ({bus.ce_p, bus.ce_n, bus.ce_pix, bus.ce_1m, bus.speed, bus.por_n} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.ce_p, bus.ce_n, bus.ce_pix, bus.ce_1m, bus.speed, bus.por_n});
    else n_pass++;
  endtask

  task automatic test_cpu_normal();
    logic ep, en;
    do_reset(1'b0);
    q_p = '{6, 12, 18};
    q_n = '{3, 9, 15};
    for (int k = 1; k <= 18; k++) begin
      @(posedge clock); #1;
      ep = (q_p.size() != 0 && q_p[0] == k);
      en = (q_n.size() != 0 && q_n[0] == k);
      n_total++;
      if (bus.ce_p !== ep) $display("FAIL normal_ce_p edge %0d: got %b expected %b", k, bus.ce_p, ep);
      else n_pass++;
      n_total++;
      if (bus.ce_n !== en) $display("FAIL normal_ce_n edge %0d: got %b expected %b", k, bus.ce_n, en);
      else n_pass++;
      n_total++;
      if (bus.speed !== 1'b0) $display("FAIL normal_speed edge %0d: got %b expected 0", k, bus.speed);
      else n_pass++;
      if (ep) void'(q_p.pop_front());
      if (en) void'(q_n.pop_front());
    end
  endtask

  task automatic test_turbo_start();
    logic ep, en, es;
    do_reset(1'b1);
    q_p = '{6, 10, 14};
    q_n = '{3, 8, 12};
    for (int k = 1; k <= 14; k++) begin
      @(posedge clock); #1;
      ep = (q_p.size() != 0 && q_p[0] == k);
      en = (q_n.size() != 0 && q_n[0] == k);
      es = (k >= 6);
      n_total++;
      if (bus.ce_p !== ep) $display("FAIL turbo_ce_p edge %0d: got %b expected %b", k, bus.ce_p, ep);
      else n_pass++;
      n_total++;
      if (bus.ce_n !== en) $display("FAIL turbo_ce_n edge %0d: got %b expected %b", k, bus.ce_n, en);
      else n_pass++;
      n_total++;
      if (bus.speed !== es) $display("FAIL turbo_speed edge %0d: got %b expected %b", k, bus.speed, es);
      else n_pass++;
      if (ep) void'(q_p.pop_front());
      if (en) void'(q_n.pop_front());
    end
  endtask

  task automatic test_pix_1m();
    logic ex, em;
    do_reset(1'b0);
    for (int i = 1; i <= 24; i++) q_pix.push_back(2 * i);
    q_1m = '{24, 48};
    for (int k = 1; k <= 48; k++) begin
      bus.turbo = logic'(k % 3 == 0);
      @(posedge clock); #1;
      ex = (q_pix.size() != 0 && q_pix[0] == k);
      em = (q_1m.size() != 0 && q_1m[0] == k);
      n_total++;
      if (bus.ce_pix !== ex) $display("FAIL ce_pix edge %0d: got %b expected %b", k, bus.ce_pix, ex);
      else n_pass++;
      n_total++;
      if (bus.ce_1m !== em) $display("FAIL ce_1m edge %0d: got %b expected %b", k, bus.ce_1m, em);
      else n_pass++;
      if (ex) void'(q_pix.pop_front());
      if (em) void'(q_1m.pop_front());
    end
    n_total++;
    if (q_pix.size() != 0 || q_1m.size() != 0)
      $display("FAIL pix_1m_missing: got %0d/%0d left expected 0/0", q_pix.size(), q_1m.size());
    else n_pass++;
  endtask

  task automatic test_por();
    logic er;
    do_reset(1'b1);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock); #1;
      er = (k >= 16);
      n_total++;
      if (bus.por_n !== er) $display("FAIL por_n edge %0d: got %b expected %b", k, bus.por_n, er);
      else n_pass++;
    end
    n_total++;
    if (bus.speed !== 1'b1) $display("FAIL por_speed_before: got %b expected 1", bus.speed);
    else n_pass++;
    reset = 1'b0;
    #2;
    n_total++;
    if (bus.por_n !== 1'b0) $display("FAIL por_async_drop: got %b expected 0", bus.por_n);
    else n_pass++;
    n_total++;
    if (bus.speed !== 1'b0) $display("FAIL por_speed_reset: got %b expected 0", bus.speed);
    else n_pass++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      er = (k >= 16);
      n_total++;
      if (bus.por_n !== er) $display("FAIL por_n_restart edge %0d: got %b expected %b", k, bus.por_n, er);
      else n_pass++;
    end
  endtask

  // random_mode=0 toggles turbo every cycle; random_mode=1 drives random back-to-back requests.
  task automatic test_turbo_toggle(input bit random_mode);
    logic t, ep, en, sp;
    int   nb, d, last_p;
    do_reset(1'b0);
    nb     = 6;
    sp     = 1'b0;
    last_p = 0;
    q_p.push_back(6);
    q_n.push_back(3);
    for (int k = 1; k <= 60; k++) begin
      t = random_mode ? 1'($urandom_range(1, 0)) : logic'(k % 2 == 0);
      bus.turbo = t;
      if (k == nb) begin
        d  = t ? 4 : 6;
        nb = k + d;
        q_p.push_back(nb);
        q_n.push_back(k + d / 2);
        sp = t;
      end
      @(posedge clock); #1;
      ep = (q_p.size() != 0 && q_p[0] == k);
      en = (q_n.size() != 0 && q_n[0] == k);
      n_total++;
      if (bus.ce_p !== ep) $display("FAIL toggle_ce_p edge %0d: got %b expected %b", k, bus.ce_p, ep);
      else n_pass++;
      n_total++;
      if (bus.ce_n !== en) $display("FAIL toggle_ce_n edge %0d: got %b expected %b", k, bus.ce_n, en);
      else n_pass++;
      n_total++;
      if (bus.speed !== sp) $display("FAIL toggle_speed edge %0d: got %b expected %b", k, bus.speed, sp);
      else n_pass++;
      n_total++;
      if ((bus.ce_p & bus.ce_n) !== 1'b0) $display("FAIL toggle_overlap edge %0d: got 1 expected 0", k);
      else n_pass++;
      if (bus.ce_p === 1'b1) begin
        if (last_p != 0) begin
          n_total++;
          if ((k - last_p) != 4 && (k - last_p) != 6)
            $display("FAIL toggle_spacing edge %0d: got %0d expected 4 or 6", k, k - last_p);
          else n_pass++;
        end
        last_p = k;
      end
      if (ep) void'(q_p.pop_front());
      if (en) void'(q_n.pop_front());
    end
  endtask

`ifdef CE_WAIT_EN
  task automatic test_wait();
    logic ep, en, ex;
    do_reset(1'b0);
    q_p = '{10, 16};
    q_n = '{3, 13};
    for (int k = 1; k <= 18; k++) begin
      bus.wait_n = !(k >= 6 && k <= 9);
      @(posedge clock); #1;
      ep = (q_p.size() != 0 && q_p[0] == k);
      en = (q_n.size() != 0 && q_n[0] == k);
      ex = (k % 2 == 0);
      n_total++;
      if (bus.ce_p !== ep) $display("FAIL wait_ce_p edge %0d: got %b expected %b", k, bus.ce_p, ep);
      else n_pass++;
      n_total++;
      if (bus.ce_n !== en) $display("FAIL wait_ce_n edge %0d: got %b expected %b", k, bus.ce_n, en);
      else n_pass++;
      n_total++;
      if (bus.ce_pix !== ex) $display("FAIL wait_ce_pix edge %0d: got %b expected %b", k, bus.ce_pix, ex);
      else n_pass++;
      if (ep) void'(q_p.pop_front());
      if (en) void'(q_n.pop_front());
    end
    bus.wait_n = 1'b1;
  endtask
`endif

  initial begin
    bus.turbo = 1'b0;
`ifdef CE_WAIT_EN
    bus.wait_n = 1'b1;
`endif
    test_reset();
    test_cpu_normal();
    test_turbo_start();
    test_pix_1m();
    test_por();
    test_turbo_toggle(1'b0);
    test_turbo_toggle(1'b1);
`ifdef CE_WAIT_EN
    test_wait();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
